frame_write_arbiter: RTL



---
 rtl/frame_write_arbiter_if.sv | 30 +++
 rtl/frame_write_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/frame_write_arbiter_if.sv
// Request-side bundle between the three pixel producers and frame_write_arbiter.
// Each producer holds reqN with a stable addrN/dataN until it sees a one-cycle ackN.
interface frame_write_arbiter_if;
    logic        req0;
    logic        req1;
    logic        req2;
    logic [14:0] addr0;
    logic [14:0] addr1;
    logic [14:0] addr2;
    logic [23:0] data0;
    logic [23:0] data1;
    logic [23:0] data2;
    logic        ack0;
    logic        ack1;
    logic        ack2;

    modport master (
        output req0, req1, req2,
        output addr0, addr1, addr2,
        output data0, data1, data2,
        input  ack0, ack1, ack2
    );

    modport slave (
        input  req0, req1, req2,
        input  addr0, addr1, addr2,
        input  data0, data1, data2,
        output ack0, ack1, ack2
    );
endinterface

// File: rtl/frame_write_arbiter.sv
// Round-robin owner of the VGA frame-buffer write port; one pixel per grant, strobe held HOLD_CYCLES.
// Define FRAME_WRITE_ADDR_CHECK_EN to reject addresses >= FB_DEPTH with an err pulse instead of writing.
module frame_write_arbiter #(
    parameter int HOLD_CYCLES = 3,
    parameter int FB_DEPTH    = 19200
) (
    input  logic                 clk,
    input  logic                 rst,
    frame_write_arbiter_if.slave producers,
    output logic [2:0]           grant,
    output logic                 busy,
    output logic                 err,
    output logic [14:0]          the_vga_draw_frame_write_mem_address,
    output logic [23:0]          the_vga_draw_frame_write_mem_data,
    output logic                 the_vga_draw_frame_write_a_pixel
);
    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        RELEASE
    } state_t;

    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_hold
        $error("frame_write_arbiter: HOLD_CYCLES must be within 1..15");
    end
    if (FB_DEPTH < 1 || FB_DEPTH > 32768) begin : g_bad_depth
        $error("frame_write_arbiter: FB_DEPTH must be within 1..32768");
    end

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

    state_t      r_state;
    logic [1:0]  r_last;
    logic [3:0]  r_cnt;
    logic [2:0]  r_grant;
    logic [2:0]  r_ack;
    logic [14:0] r_addr;
    logic [23:0] r_data;
    logic        r_we;

    state_t      w_state;
    logic [1:0]  w_last;
    logic [3:0]  w_cnt;
    logic [2:0]  w_grant;
    logic [2:0]  w_ack;
    logic [14:0] w_addr;
    logic [23:0] w_data;
    logic        w_we;

    logic [2:0]  w_req;
    logic [1:0]  w_winner;
    logic [2:0]  w_winOneHot;
    logic [14:0] w_winAddr;
    logic [23:0] w_winData;

`ifdef FRAME_WRITE_ADDR_CHECK_EN
    logic        r_err;
    logic        w_err;
`endif

    assign w_req = {producers.req2, producers.req1, producers.req0};

    // Search starts just after the last owner, so the previous winner is considered last.
    always_comb begin
        w_winner = r_last;
        case (r_last)
            2'd0: begin
                if (w_req[1])      w_winner = 2'd1;
                else if (w_req[2]) w_winner = 2'd2;
                else               w_winner = 2'd0;
            end
            2'd1: begin
                if (w_req[2])      w_winner = 2'd2;
                else if (w_req[0]) w_winner = 2'd0;
                else               w_winner = 2'd1;
            end
            default: begin
                if (w_req[0])      w_winner = 2'd0;
                else if (w_req[1]) w_winner = 2'd1;
                else               w_winner = 2'd2;
            end
        endcase
    end

    assign w_winOneHot = 3'b001 << w_winner;

    always_comb begin
        w_winAddr = producers.addr2;
        w_winData = producers.data2;
        case (w_winner)
            2'd0: begin
                w_winAddr = producers.addr0;
                w_winData = producers.data0;
            end
            2'd1: begin
                w_winAddr = producers.addr1;
                w_winData = producers.data1;
            end
            default: begin
                w_winAddr = producers.addr2;
                w_winData = producers.data2;
            end
        endcase
    end

    always_comb begin
        w_state = r_state;
        w_last  = r_last;
        w_cnt   = r_cnt;
        w_grant = r_grant;
        w_ack   = 3'b000;
        w_addr  = r_addr;
        w_data  = r_data;
        w_we    = r_we;
`ifdef FRAME_WRITE_ADDR_CHECK_EN
        w_err   = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (|w_req) begin
                    w_grant = w_winOneHot;
                    w_last  = w_winner;
                    w_cnt   = 4'd0;
`ifdef FRAME_WRITE_ADDR_CHECK_EN
                    // Out-of-range pixels still consume their turn so the pointer keeps rotating.
                    if (int'(w_winAddr) >= FB_DEPTH) begin
                        w_ack   = w_winOneHot;
                        w_err   = 1'b1;
                        w_state = RELEASE;
                    end else begin
                        w_addr  = w_winAddr;
                        w_data  = w_winData;
                        w_we    = 1'b1;
                        w_state = WRITE;
                    end
`else
                    w_addr  = w_winAddr;
                    w_data  = w_winData;
                    w_we    = 1'b1;
                    w_state = WRITE;
`endif
                end
            end
            WRITE: begin
                w_cnt = r_cnt + 4'd1;
                if (r_cnt == HOLD_LAST) begin
                    w_we    = 1'b0;
                    w_ack   = r_grant;
                    w_state = RELEASE;
                end
            end
            RELEASE: begin
                w_grant = 3'b000;
                w_state = IDLE;
            end
            default: begin
                w_grant = 3'b000;
                w_we    = 1'b0;
                w_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_last  <= 2'd2;
            r_cnt   <= 4'd0;
            r_grant <= 3'b000;
            r_ack   <= 3'b000;
            r_addr  <= 15'd0;
            r_data  <= 24'd0;
            r_we    <= 1'b0;
`ifdef FRAME_WRITE_ADDR_CHECK_EN
            r_err   <= 1'b0;
`endif
        end else begin
            r_state <= w_state;
            r_last  <= w_last;
            r_cnt   <= w_cnt;
            r_grant <= w_grant;
            r_ack   <= w_ack;
            r_addr  <= w_addr;
            r_data  <= w_data;
            r_we    <= w_we;
`ifdef FRAME_WRITE_ADDR_CHECK_EN
            r_err   <= w_err;
`endif
        end
    end

    assign producers.ack0 = r_ack[0];
    assign producers.ack1 = r_ack[1];
    assign producers.ack2 = r_ack[2];

    assign grant = r_grant;
    assign busy  = (r_state != IDLE);
`ifdef FRAME_WRITE_ADDR_CHECK_EN
    assign err   = r_err;
`else
    assign err   = 1'b0;
`endif

    assign the_vga_draw_frame_write_mem_address = r_addr;
    assign the_vga_draw_frame_write_mem_data    = r_data;
    assign the_vga_draw_frame_write_a_pixel     = r_we;
endmodule
